// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port between two single-beat requesters.
// The arbiter owns all RAM port timing, including the read-latency wait.
module ram_port_arbiter #(
  parameter int REG_SIZE = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [REG_SIZE-1:0] m0_addr,
  input  logic [REG_SIZE-1:0] m0_wdata,
  output logic                m0_gnt,
  output logic                m0_done,
  output logic [REG_SIZE-1:0] m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [REG_SIZE-1:0] m1_addr,
  input  logic [REG_SIZE-1:0] m1_wdata,
  output logic                m1_gnt,
  output logic                m1_done,
  output logic [REG_SIZE-1:0] m1_rdata,
  output logic [REG_SIZE-1:0] ram_addr,
  output logic                ram_we,
  output logic [REG_SIZE-1:0] ram_wdata,
  input  logic [REG_SIZE-1:0] ram_rdata,
  output logic [1:0]          dbg_state
);

  // Handshake: a master holds req/we/addr/wdata until its one-cycle gnt pulse, at which
  // point the op is latched; dropping req before gnt withdraws it; done pulses once at completion.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [REG_SIZE-1:0] addr_q, addr_d;
  logic [REG_SIZE-1:0] wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [REG_SIZE-1:0] rdata0_q, rdata0_d;
  logic [REG_SIZE-1:0] rdata1_q, rdata1_d;

  logic sel_valid;
  logic sel_id;
  logic rd_sample;

  // Ties go to the master that was not served last.
  always_comb begin
    sel_valid = m0_req | m1_req;
    sel_id    = 1'b0;
    if (m0_req && m1_req) begin
      sel_id = ~last_q;
    end else if (m1_req) begin
      sel_id = 1'b1;
    end
  end

  always_comb begin
    rd_sample = 1'b0;
    if (state_q == S_ISSUE && !we_q && RD_LAT == 0) begin
      rd_sample = 1'b1;
    end else if (state_q == S_WAIT_RD && cnt_q == 3'd1) begin
      rd_sample = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 3'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d = S_ISSUE;
          owner_d = sel_id;
          we_d    = sel_id ? m1_we    : m0_we;
          addr_d  = sel_id ? m1_addr  : m0_addr;
          wdata_d = sel_id ? m1_wdata : m0_wdata;
        end
      end
      S_ISSUE: begin
        if (we_q || RD_LAT == 0) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Only the owner's read data register ever changes.
    if (rd_sample) begin
      if (owner_q) begin
        rdata1_d = ram_rdata;
      end else begin
        rdata0_d = ram_rdata;
      end
    end
  end

  // Outputs are forced quiet while reset is held so an aborted op shows nothing.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            m0_gnt = ~sel_id;
            m1_gnt = sel_id;
          end
        end
        S_ISSUE: begin
          ram_addr  = addr_q;
          ram_we    = we_q;
          ram_wdata = we_q ? wdata_q : '0;
        end
        S_WAIT_RD: begin
          ram_addr = addr_q;
        end
        S_RESP: begin
          m0_done = ~owner_q;
          m1_done = owner_q;
        end
        default: ;
      endcase
    end
  end

  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-timeline reference model, RAM stub with
// configurable read latency, directed scenarios and randomized two-master traffic.
module tb_ram_port_arbiter;
  localparam int W    = 8;
  localparam int L    = 1;
  localparam int PIDX = (L == 0) ? 0 : L - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]   req_a = 2'b00;
  logic [1:0]   we_a  = 2'b00;
  logic [W-1:0] addr_a[2];
  logic [W-1:0] wd_a[2];

  logic         m0_gnt, m1_gnt, m0_done, m1_done, ram_we;
  logic [W-1:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.REG_SIZE(W), .RD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req_a[0]), .m0_we(we_a[0]), .m0_addr(addr_a[0]), .m0_wdata(wd_a[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(req_a[1]), .m1_we(we_a[1]), .m1_addr(addr_a[1]), .m1_wdata(wd_a[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
    if (a == 8'h20) return 8'h3C;
    return a * 8'd29 + 8'd7;
  endfunction

  // RAM stub: data for an address presented in cycle c appears in cycle c+L.
  logic [W-1:0] mem[256];
  bit           wvalid[256];
  logic [W-1:0] apipe[8];
  logic [W-1:0] rd_addr;
  always @(posedge clk) begin
    apipe[0] <= ram_addr;
    for (int k = 1; k < 8; k++) apipe[k] <= apipe[k-1];
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      wvalid[ram_addr] <= 1'b1;
    end
  end
  assign rd_addr   = (L == 0) ? ram_addr : apipe[PIDX];
  assign ram_rdata = wvalid[rd_addr] ? mem[rd_addr] : init_val(rd_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, timed from its grant cycle.
  bit           in_txn = 1'b0;
  int           cyc = 0;
  int           t_g = 0;
  logic         t_own, t_we, last_m = 1'b1;
  logic [W-1:0] t_addr, t_wd;
  logic [W-1:0] exp_rd[2] = '{default: '0};
  logic [W-1:0] mmem[256];
  bit           mw[256];

  always @(negedge clk) begin : model
    logic [1:0]   e_gnt, e_done;
    logic [W-1:0] e_addr, e_wd;
    logic         e_we, sel;
    int           ph, iss_end, done_ph;
    bit           grant_now, fin_now;
    if (!rst) begin
      in_txn    = 1'b0;
      last_m    = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      e_gnt = 2'b00; e_done = 2'b00; e_addr = '0; e_wd = '0; e_we = 1'b0;
      grant_now = 1'b0; fin_now = 1'b0;
      if (in_txn) begin
        ph      = cyc - t_g;
        iss_end = t_we ? 1 : 1 + L;
        done_ph = iss_end + 1;
        if (ph >= 1 && ph <= iss_end) begin
          e_addr = t_addr;
          e_we   = t_we && (ph == 1);
          e_wd   = t_we ? t_wd : '0;
        end
        if (ph == done_ph) begin
          e_done[t_own] = 1'b1;
          fin_now = 1'b1;
          if (t_we) begin
            mmem[t_addr] = t_wd;
            mw[t_addr]   = 1'b1;
          end else begin
            exp_rd[t_own] = mw[t_addr] ? mmem[t_addr] : init_val(t_addr);
          end
        end
      end else if (req_a != 2'b00) begin
        sel = (req_a == 2'b11) ? ~last_m : req_a[1];
        e_gnt[sel] = 1'b1;
        grant_now  = 1'b1;
        t_own = sel; t_we = we_a[sel]; t_addr = addr_a[sel]; t_wd = wd_a[sel]; t_g = cyc;
      end
      chk("m0_gnt", m0_gnt, e_gnt[0]);
      chk("m1_gnt", m1_gnt, e_gnt[1]);
      chk("m0_done", m0_done, e_done[0]);
      chk("m1_done", m1_done, e_done[1]);
      chk("m0_rdata", m0_rdata, exp_rd[0]);
      chk("m1_rdata", m1_rdata, exp_rd[1]);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_we", ram_we, e_we);
      chk("ram_wdata", ram_wdata, e_wd);
      if (fin_now) begin
        in_txn = 1'b0;
        last_m = t_own;
      end else if (grant_now) begin
        in_txn = 1'b1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    req_a[m] = 1'b1; we_a[m] = we; addr_a[m] = a; wd_a[m] = d;
  endtask

  task automatic new_req(input int m);
    set_req(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)), 8'($urandom_range(0, 255)));
  endtask

  task automatic drain();
    logic [1:0] g;
    for (int k = 0; k < 100 && req_a != 2'b00; k++) begin
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      tick();
      req_a = req_a & ~g;
    end
    chk("drain_all_granted", req_a, 0);
  endtask

  task automatic settle();
    req_a = 2'b00;
    repeat (10) tick();
  endtask

  initial begin : main
    logic [1:0] g;
    int n, cyc_l, last_t, gap;
    bit found;
    int ord[6];
    addr_a[0] = '0; addr_a[1] = '0; wd_a[0] = '0; wd_a[1] = '0;

    // Reset values
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("R_gnt", {m1_gnt, m0_gnt}, 0);
    chk("R_done", {m1_done, m0_done}, 0);
    chk("R_rdata", {m1_rdata, m0_rdata}, 0);
    chk("R_ram", {ram_addr, ram_we, ram_wdata}, 0);
    chk("R_state_idle", dbg_state, 0);

    // Both masters write continuously from the first cycle after reset
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 8'h30, 8'hC0);
    set_req(1, 1'b1, 8'h31, 8'hC1);
    n = 0; cyc_l = 0; last_t = 0;
    while (n < 6 && cyc_l < 100) begin
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      if (g != 2'b00) begin
        ord[n] = int'(g[1]);
        if (n > 0) chk("A_gnt_spacing", cyc_l - last_t, 3);
        last_t = cyc_l;
        n++;
      end
      tick();
      cyc_l++;
      for (int m = 0; m < 2; m++)
        if (g[m]) set_req(m, 1'b1, 8'(8'h30 + n), 8'(8'hC0 + n));
    end
    req_a = 2'b00;
    chk("A_six_grants", n, 6);
    for (int i = 0; i < 6; i++) chk("A_alternate", ord[i], i % 2);
    settle();

    // m0 write 0x10 = 0xA5
    tick(); set_req(0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk); chk("B_m0_gnt", m0_gnt, 1);
    tick(); req_a[0] = 1'b0;
    @(negedge clk);
    chk("B_ram_we", ram_we, 1); chk("B_ram_addr", ram_addr, 8'h10); chk("B_ram_wdata", ram_wdata, 8'hA5);
    @(negedge clk);
    chk("B_m0_done", m0_done, 1); chk("B_ram_we_off", ram_we, 0); chk("B_m1_rdata", m1_rdata, 0);
    settle();

    // m1 read 0x20 (preloaded 0x3C), then m0 read 0x10
    tick(); set_req(1, 1'b0, 8'h20, 8'h00);
    @(negedge clk); chk("C_m1_gnt", m1_gnt, 1);
    tick(); req_a[1] = 1'b0;
    @(negedge clk); chk("C_ram_addr_iss", ram_addr, 8'h20); chk("C_ram_we", ram_we, 0);
    for (int i = 0; i < L; i++) begin
      @(negedge clk); chk("C_ram_addr_wait", ram_addr, 8'h20);
    end
    @(negedge clk); chk("C_m1_done", m1_done, 1); chk("C_m1_rdata", m1_rdata, 8'h3C);
    tick(); set_req(0, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("C_m0_gnt", m0_gnt, 1);
    tick(); req_a[0] = 1'b0;
    repeat (2 + L) @(negedge clk);
    chk("C_m0_done", m0_done, 1); chk("C_m0_rdata", m0_rdata, 8'hA5); chk("C_m1_rdata_held", m1_rdata, 8'h3C);
    settle();

    // m1 back-to-back reads with req held
    tick(); set_req(1, 1'b0, 8'h20, 8'h00);
    @(negedge clk); chk("D_gnt1", m1_gnt, 1);
    tick(); set_req(1, 1'b0, 8'h10, 8'h00);
    gap = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      gap++;
      if (m1_gnt) found = 1'b1;
    end
    chk("D_second_gnt_gap", gap, 3 + L);
    tick(); req_a[1] = 1'b0;
    repeat (2 + L) @(negedge clk);
    chk("D_m1_done", m1_done, 1); chk("D_m1_rdata", m1_rdata, 8'hA5);
    settle();

    // Reset during an m0 read's wait, then a tie
    tick(); set_req(0, 1'b0, 8'h20, 8'h00);
    @(negedge clk); chk("E_m0_gnt", m0_gnt, 1);
    tick(); req_a[0] = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("E_no_done", {m1_done, m0_done}, 0); chk("E_m0_rdata", m0_rdata, 0);
    chk("E_m1_rdata", m1_rdata, 0); chk("E_ram_addr", ram_addr, 0);
    tick(); set_req(0, 1'b1, 8'h40, 8'h11); set_req(1, 1'b1, 8'h41, 8'h22);
    @(negedge clk); chk("E_tie_m0", m0_gnt, 1); chk("E_tie_m1", m1_gnt, 0);
    drain();
    settle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      tick();
      for (int m = 0; m < 2; m++) begin
        if (req_a[m]) begin
          if (g[m]) begin
            req_a[m] = 1'b0;
            if ($urandom_range(0, 3) != 0) new_req(m);
          end else if ($urandom_range(0, 31) == 0) begin
            req_a[m] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          new_req(m);
        end
      end
    end
    drain();
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
